systolic_controller: RTL and testbench

SYSTOLIC_CONTROLLER -- requirements
Module: systolic_controller

---
 rtl/systolic_controller.sv | 174 +++++++++++++++++
 tb/tb_systolic_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_controller.sv
// Sequencer for an ARRAY_SIZE x ARRAY_SIZE weight-stationary systolic array:
// clears accumulators, loads weights, streams activations, drains, and returns one result beat.
module systolic_controller #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CNT_WIDTH-1:0]             num_vectors,
  output logic                             busy,
  output logic                             done,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
  output logic                             arr_enable,
  output logic                             arr_load_weights,
  output logic                             arr_clear_acc,
  output logic                             arr_acc_enable,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_weight_flat,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_act_flat,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  arr_results_flat,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  res_data
);

  localparam int WCNT_W = $clog2(ARRAY_SIZE + 1);
  localparam int DCNT_W = $clog2(2 * ARRAY_SIZE + 1);
  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(ARRAY_SIZE - 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(2 * ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_W,
    COMPUTE,
    DRAIN,
    OUTPUT,
    DONE
  } state_t;

  state_t                          state_reg, state_next;
  logic [CNT_WIDTH-1:0]            vec_cnt_reg, vec_cnt_next;
  logic [WCNT_W-1:0]               w_cnt_reg, w_cnt_next;
  logic [DCNT_W-1:0]               drain_cnt_reg, drain_cnt_next;
  logic                            res_valid_reg, res_valid_next;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0] res_data_reg, res_data_next;
  logic                            w_beat, a_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      vec_cnt_reg   <= '0;
      w_cnt_reg     <= '0;
      drain_cnt_reg <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      vec_cnt_reg   <= vec_cnt_next;
      w_cnt_reg     <= w_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    vec_cnt_next     = vec_cnt_reg;
    w_cnt_next       = w_cnt_reg;
    drain_cnt_next   = drain_cnt_reg;
    res_valid_next   = res_valid_reg;
    res_data_next    = res_data_reg;
    w_beat           = 1'b0;
    a_beat           = 1'b0;
    w_ready          = 1'b0;
    a_ready          = 1'b0;
    arr_enable       = 1'b0;
    arr_load_weights = 1'b0;
    arr_clear_acc    = 1'b0;
    arr_acc_enable   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          vec_cnt_next   = num_vectors;
          w_cnt_next     = '0;
          drain_cnt_next = '0;
          state_next     = CLEAR;
        end
      end
      CLEAR: begin
        arr_clear_acc = 1'b1;
        state_next    = LOAD_W;
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_beat           = 1'b1;
          arr_enable       = 1'b1;
          arr_load_weights = 1'b1;
          if (w_cnt_reg == W_LAST) begin
            w_cnt_next = '0;
            // A zero-length job has nothing to stream; go straight to flushing the array.
            state_next = (vec_cnt_reg == '0) ? DRAIN : COMPUTE;
          end else begin
            w_cnt_next = w_cnt_reg + 1'b1;
          end
        end
      end
      COMPUTE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          a_beat         = 1'b1;
          arr_enable     = 1'b1;
          arr_acc_enable = 1'b1;
          vec_cnt_next   = vec_cnt_reg - 1'b1;
          if (vec_cnt_reg == CNT_WIDTH'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Zero activations push the last partial sums through the skewed array.
        arr_enable     = 1'b1;
        arr_acc_enable = 1'b1;
        if (drain_cnt_reg == D_LAST) begin
          drain_cnt_next = '0;
          res_valid_next = 1'b1;
          res_data_next  = arr_results_flat;
          state_next     = OUTPUT;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Data lanes are forced to zero except on an accepted handshake beat.
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      assign arr_weight_flat[gi*DATA_WIDTH +: DATA_WIDTH] =
        w_beat ? w_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign arr_act_flat[gi*DATA_WIDTH +: DATA_WIDTH] =
        a_beat ? a_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;

endmodule

// File: tb/tb_systolic_controller.sv
// Directed bench for systolic_controller: scoreboard on the result stream plus
// per-job cycle, beat and latency counts.
module tb_systolic_controller;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int CW = 8;
  localparam int VW = N * DW;
  localparam int RW = N * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_vectors = '0;
  logic          busy, done;
  logic          w_valid = 1'b0, w_ready;
  logic [VW-1:0] w_data = '0;
  logic          a_valid = 1'b0, a_ready;
  logic [VW-1:0] a_data = '0;
  logic          arr_enable, arr_load_weights, arr_clear_acc, arr_acc_enable;
  logic [VW-1:0] arr_weight_flat, arr_act_flat;
  logic [RW-1:0] arr_results_flat = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [RW-1:0] res_data;

  always #5 clk = ~clk;

  systolic_controller #(
    .ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .arr_enable(arr_enable), .arr_load_weights(arr_load_weights),
    .arr_clear_acc(arr_clear_acc), .arr_acc_enable(arr_acc_enable),
    .arr_weight_flat(arr_weight_flat), .arr_act_flat(arr_act_flat),
    .arr_results_flat(arr_results_flat),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  int n_clear, n_load, n_acc, n_drain, n_aready, n_done, n_rv;

  function automatic void check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: per-cycle invariants, activity counters and result scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      n_clear  += int'(arr_clear_acc);
      n_load   += int'(arr_load_weights);
      n_acc    += int'(arr_acc_enable);
      n_drain  += int'(arr_enable && arr_acc_enable && !a_ready);
      n_aready += int'(a_ready);
      n_done   += int'(done);
      if (w_ready && a_ready) check("ready_overlap", 1, 0);
      if (arr_load_weights) check("weight_lane", arr_weight_flat, w_data);
      else if (arr_weight_flat != '0) check("weight_idle", arr_weight_flat, 0);
      if (a_ready && a_valid) check("act_lane", arr_act_flat, a_data);
      else if (arr_act_flat != '0) check("act_idle", arr_act_flat, 0);
      if (!busy && (arr_enable || arr_clear_acc || arr_acc_enable || arr_load_weights))
        check("idle_ctrl", 1, 0);
      if (res_valid) begin
        n_rv++;
        if (exp_q.size() == 0) begin
          check("res_unexpected", res_valid, 0);
        end else begin
          check("res_data", res_data, exp_q[0]);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic run_job(input string tag, input int nv, input bit w_toggle,
                         input int res_hold, input bit poke, input logic [RW-1:0] result);
    int k;
    int exp_lat;
    arr_results_flat = result;
    exp_q.push_back(result);
    n_clear = 0; n_load = 0; n_acc = 0; n_drain = 0; n_aready = 0; n_done = 0; n_rv = 0;
    start = 1'b1;
    num_vectors = CW'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    num_vectors = 8'hA5;
    k = 0;
    forever begin
      w_valid   = w_toggle ? k[0] : 1'b1;
      a_valid   = 1'b1;
      w_data    = {$urandom(), $urandom()};
      a_data    = {$urandom(), $urandom()};
      res_ready = (n_rv >= res_hold);
      if (poke && k == 6) begin
        start = 1'b1;
        num_vectors = 8'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) break;
      if (k > 300) begin
        check({tag, "_timeout"}, 0, 1);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    exp_lat = 15 + nv + (w_toggle ? 3 : 0) + res_hold;
    check({tag, "_latency"}, k + 1, exp_lat);
    @(posedge clk); #1;
    start = 1'b0; w_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_n_clear"}, n_clear, 1);
    check({tag, "_n_load"}, n_load, N);
    check({tag, "_n_acc"}, n_acc, nv + 2 * N);
    check({tag, "_n_drain"}, n_drain, 2 * N);
    check({tag, "_n_aready"}, n_aready, nv);
    check({tag, "_n_rv"}, n_rv, res_hold + 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    $display("job %s nv=%0d latency=%0d expected=%0d", tag, nv, k + 1, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic reset_in_drain();
    n_done = 0; n_rv = 0;
    arr_results_flat = {4{32'hDEAD_BEEF}};
    start = 1'b1;
    num_vectors = 8'd2;
    w_valid = 1'b1;
    a_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rst_pre_drain_en", arr_enable && arr_acc_enable && !a_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ctrl", {arr_enable, arr_load_weights, arr_clear_acc, arr_acc_enable}, 0);
    check("rst_ready", {w_ready, a_ready}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_flat", {arr_weight_flat, arr_act_flat}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0; n_rv = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_after_busy", busy, 0);
    check("rst_after_n_done", n_done, 0);
    check("rst_after_n_rv", n_rv, 0);
    $display("job reset_in_drain done_pulses=%0d", n_done);
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_ctrl", {arr_enable, arr_load_weights, arr_clear_acc, arr_acc_enable, w_ready, a_ready}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job("basic", 3, 1'b0, 0, 1'b0, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
    run_job("wgap",  3, 1'b1, 0, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    run_job("zero",  0, 1'b0, 0, 1'b0, 128'hCAFE_F00D_0000_0001_8000_0000_FFFF_FFFF);
    run_job("hold",  2, 1'b0, 5, 1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    run_job("poke",  3, 1'b0, 0, 1'b1, 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0);
    reset_in_drain();
    run_job("recover", 1, 1'b0, 0, 1'b0, 128'h7777_0000_3333_0000_1111_0000_9999_0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
